// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: widths, opcode values and fetch state encoding.
package fetch_unit_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0]        OPC_HALT = 4'b1111;
  localparam logic [3:0]        OPC_NOP  = 4'b0000;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'd0;

  typedef enum logic {
    FS_FETCH  = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return (instr[15:12] == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Valid/ready channel carrying a fetched instruction and its address to decode.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and registers
// each word for decode. Fetch stops on HALT and restarts only on a branch redirect.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  fetch_unit_if.master       dec,
  output logic               halted
);

  fetch_state_e       state_r;
  logic [ADDR_W-1:0]  pc_r;
  logic               valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  opc_r;
  logic               load_s;

  // A branch always suppresses the load so a HALT word under a redirect is never captured.
  always_comb begin
    load_s = (state_r == FS_FETCH) && (!valid_r || dec.out_ready) && !branch_valid;
  end

  // PC, output register and fetch FSM advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FS_FETCH;
      pc_r    <= RESET_PC;
      valid_r <= 1'b0;
      instr_r <= 16'h0000;
      opc_r   <= 8'd0;
    end else begin
      if (branch_valid) begin
        pc_r    <= branch_target;
        valid_r <= 1'b0;
        state_r <= FS_FETCH;
      end else if (load_s) begin
        instr_r <= imem_instr;
        opc_r   <= pc_r;
        valid_r <= 1'b1;
        if (is_halt(imem_instr)) begin
          state_r <= FS_HALTED;
        end else begin
          pc_r <= pc_r + 8'd1;
        end
      end else if (valid_r && dec.out_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign imem_addr     = pc_r;
  assign dec.out_valid = valid_r;
  assign dec.out_instr = instr_r;
  assign dec.out_pc    = opc_r;
  assign halted        = (state_r == FS_HALTED);

endmodule
